regbank_scanner: RTL and testbench

Read-side sequencer for the register bank. It drives the bank's read address and steps through every register, either automatically with a programmable dwell time or one register per push of a step button. It registers the address and data it read so the 7-segment decoders show a coherent address/data pair. It sits between the bank's combinational read port and the display decoders, in the top level next to the switch and button write path.

---
 rtl/regbank_pkg.sv | 14 +
 rtl/sync_edge.sv | 36 +++
 rtl/regbank_scanner.sv | 114 +++++++++++
 tb/tb_regbank_scanner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank and its read-side scanner.
//   BANK_BIT_ADDR / BANK_BIT_DATO : default address / data widths of the bank
//   scan_state_t                  : scanner mode (manual step or auto dwell)
package regbank_pkg;

  localparam int BANK_BIT_ADDR = 2;
  localparam int BANK_BIT_DATO = 4;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk, rst : clock, async active-high reset (all flops clear to 0)
//   din      : asynchronous level from a pad
//   level_s  : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level_s,
  output logic rise
);

  logic       meta;
  logic       prev;
  logic [2:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      level_s  <= 1'b0;
      prev     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      meta     <= din;
      level_s  <= meta;
      prev     <= level_s;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  // prev only holds a real pad sample three edges after reset; until then
  // its reset 0 would turn a button held through reset into a fake edge.
  assign rise = level_s & ~prev & vld_pipe[2];

endmodule

// File: rtl/regbank_scanner.sv
// Read-side sequencer for the register bank: steps the read address either
// automatically (DWELL cycles per register) or once per step-button press,
// and registers an address/data pair for the 7-segment decoders.
//   clk, rst  : clock, async active-high reset
//   run       : async switch, 1 = auto-scan, 0 = manual
//   step      : async push button, rising edge advances in manual mode
//   rd_addr   : registered read address to the bank
//   rd_data   : combinational bank data for rd_addr
//   disp_addr : captured address shown on the display
//   disp_data : captured data shown on the display
//   wrap      : one-cycle pulse when rd_addr rolls over to 0
module regbank_scanner
  import regbank_pkg::*;
#(
  parameter int BIT_ADDR = BANK_BIT_ADDR,
  parameter int BIT_DATO = BANK_BIT_DATO,
  parameter int DWELL    = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                step,
  output logic [BIT_ADDR-1:0] rd_addr,
  input  logic [BIT_DATO-1:0] rd_data,
  output logic [BIT_ADDR-1:0] disp_addr,
  output logic [BIT_DATO-1:0] disp_data,
  output logic                wrap
);

  localparam int                  CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [BIT_ADDR-1:0] ADDR_LAST = '1;

  logic run_s;
  logic run_rise_unused;
  logic step_rise;
  logic step_s_unused;

  sync_edge u_run_sync (
    .clk     (clk),
    .rst     (rst),
    .din     (run),
    .level_s (run_s),
    .rise    (run_rise_unused)
  );

  sync_edge u_step_sync (
    .clk     (clk),
    .rst     (rst),
    .din     (step),
    .level_s (step_s_unused),
    .rise    (step_rise)
  );

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             adv;

  // Mode changes take priority over advancing: a step edge coinciding with
  // entry to AUTO is dropped, and leaving AUTO never advances.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    adv       = 1'b0;
    case (state)
      MANUAL: begin
        if (run_s) begin
          state_nxt = AUTO;
          cnt_nxt   = '0;
        end else begin
          adv = step_rise;
        end
      end
      AUTO: begin
        if (!run_s) begin
          state_nxt = MANUAL;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          adv     = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MANUAL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Display capture every cycle keeps disp_addr/disp_data from one cycle and
  // lets bank writes to the shown register appear one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr   <= '0;
      wrap      <= 1'b0;
      disp_addr <= '0;
      disp_data <= '0;
    end else begin
      if (adv) rd_addr <= rd_addr + BIT_ADDR'(1);
      wrap      <= adv && (rd_addr == ADDR_LAST);
      disp_addr <= rd_addr;
      disp_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_regbank_scanner.sv
module tb_regbank_scanner;

  localparam int BA    = 2;
  localparam int BD    = 4;
  localparam int NREG  = 1 << BA;
  localparam int DWELL = 4;

  logic          clk = 1'b0;
  logic          rst, run, step;
  logic [BA-1:0] rd_addr, disp_addr;
  logic [BD-1:0] rd_data, disp_data;
  logic          wrap;
  logic [BD-1:0] bank [NREG];

  assign rd_data = bank[rd_addr];

  regbank_scanner #(.BIT_ADDR(BA), .BIT_DATO(BD), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step      (step),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int chks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pads become visible two edges late, a press counts once
  // the button history holds three genuine samples, mode changes win over
  // advancing, and in auto mode an advance happens every DWELL edges.
  bit rh[3], sh[3];
  bit m_auto, m_wrap, m_adv, rs, sr;
  int m_el, m_addr, m_daddr, m_ddata, m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_auto = 0; m_el = 0; m_addr = 0; m_daddr = 0; m_ddata = 0;
      m_wrap = 0; m_age = 0;
      rh = '{0, 0, 0}; sh = '{0, 0, 0};
    end else begin
      m_daddr = m_addr;
      m_ddata = int'(bank[m_addr]);
      rs    = rh[1];
      sr    = sh[1] && !sh[2] && (m_age >= 3);
      m_adv = 0;
      if (!m_auto) begin
        if (rs) begin m_auto = 1; m_el = 0; end
        else m_adv = sr;
      end else if (!rs) begin
        m_auto = 0; m_el = 0;
      end else begin
        m_el++;
        if (m_el == DWELL) begin m_adv = 1; m_el = 0; end
      end
      m_wrap = m_adv && (m_addr == NREG - 1);
      if (m_adv) m_addr = (m_addr + 1) % NREG;
      rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = run;
      sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = step;
      if (m_age < 3) m_age++;
    end
  end

  int wrap_cnt = 0;
  always @(negedge clk) begin
    chk("m_rd_addr", 32'(rd_addr), m_addr);
    chk("m_disp_addr", 32'(disp_addr), m_daddr);
    chk("m_disp_data", 32'(disp_data), m_ddata);
    chk("m_wrap", 32'(wrap), 32'(m_wrap));
    if (wrap === 1'b1) wrap_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    step = 1'b1; cyc(4);
    step = 1'b0; cyc(4);
  endtask

  task automatic wait_addr(input int a, input int budget);
    int n = 0;
    while (32'(rd_addr) != a && n < budget) begin cyc(1); n++; end
    chk("wait_addr", 32'(rd_addr), a);
  endtask

  // Cycles until rd_addr next changes, budget+1 if it never does.
  task automatic time_change(output int n, input int budget);
    logic [BA-1:0] a0;
    a0 = rd_addr;
    n  = 0;
    while (rd_addr == a0 && n <= budget) begin cyc(1); n++; end
  endtask

  task automatic time_wrap(output int n, input int budget);
    n = 0;
    do begin cyc(1); n++; end while (wrap !== 1'b1 && n <= budget);
  endtask

  int exp_a[4] = '{1, 2, 3, 0};
  int exp_d[4] = '{5, 9, 12, 3};
  int t;

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0;
    bank[0] = 4'h3; bank[1] = 4'h5; bank[2] = 4'h9; bank[3] = 4'hC;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_disp_addr", 32'(disp_addr), 0);
    chk("rst_disp_data", 32'(disp_data), 0);
    chk("rst_wrap", 32'(wrap), 0);
    rst = 1'b0;
    cyc(5);

    // Manual stepping through the whole bank.
    wrap_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      press();
      chk("step_disp_addr", 32'(disp_addr), exp_a[k]);
      chk("step_disp_data", 32'(disp_data), exp_d[k]);
    end
    chk("step_wraps", wrap_cnt, 1);

    // Auto-scan cadence with stray step toggles that must be ignored.
    run = 1'b1;
    cyc(3);
    time_change(t, 20);
    chk("first_adv", t, DWELL);
    for (int k = 0; k < 3; k++) begin
      step = ~step;
      time_change(t, 20);
      chk("dwell", t, DWELL);
    end
    step = 1'b0;
    time_wrap(t, 40);
    time_wrap(t, 40);
    chk("wrap_period", t, NREG * DWELL);

    // Drop run just after reaching address 2.
    wait_addr(1, 40);
    wait_addr(2, 40);
    run = 1'b0;
    cyc(8);
    chk("exit_hold", 32'(rd_addr), 2);
    step = 1'b1;
    cyc(2);
    chk("step_lat2", 32'(rd_addr), 2);
    cyc(1);
    chk("step_lat3", 32'(rd_addr), 3);
    step = 1'b0;
    cyc(4);

    // Live update of the displayed register.
    press();
    press();
    chk("live_addr", 32'(rd_addr), 1);
    bank[1] = 4'hA;
    chk("live_pre", 32'(disp_data), 5);
    cyc(1);
    chk("live_post", 32'(disp_data), 10);

    // Asynchronous reset mid-scan with step held through it.
    run = 1'b1;
    cyc(3);
    wait_addr(3, 60);
    step = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_rd_addr", 32'(rd_addr), 0);
    chk("arst_disp_addr", 32'(disp_addr), 0);
    chk("arst_disp_data", 32'(disp_data), 0);
    chk("arst_wrap", 32'(wrap), 0);
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(10);
    chk("held_step", 32'(rd_addr), 0);
    step = 1'b0;
    cyc(5);
    press();
    chk("manual_after_rst", 32'(rd_addr), 1);

    // Step rising together with run: no advance, normal dwell after entry.
    run = 1'b1; step = 1'b1;
    cyc(3);
    chk("simul_entry", 32'(rd_addr), 1);
    cyc(3);
    chk("simul_dwell", 32'(rd_addr), 1);
    cyc(1);
    chk("simul_adv", 32'(rd_addr), 2);
    run = 1'b0; step = 1'b0;
    cyc(5);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 4) == 0) step = ~step;
      if ($urandom_range(0, 7) == 0) bank[$urandom_range(0, NREG - 1)] = BD'($urandom);
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
